// File: rtl/score_digit_addr_if.sv
// Score digit address interface.
// Groups the score update request, the VGA pixel coordinates and the glyph
// address outputs exchanged between the game/VGA side (master) and the
// score_digit_addr block (slave).
//   score        : binary score, sampled when score_valid is high
//   score_valid  : one-cycle update request
//   DrawX/DrawY  : current pixel column/row from the VGA controller
//   rom_address  : glyph bit address to the numbers ROM
//   in_box       : pixel lies in a non-blanked digit cell, aligned with ROM q
//   busy         : conversion or commit pending
interface score_digit_addr_if #(
    parameter int SCORE_W = 14
);
    logic [SCORE_W-1:0] score;
    logic               score_valid;
    logic [9:0]         DrawX;
    logic [9:0]         DrawY;
    logic [10:0]        rom_address;
    logic               in_box;
    logic               busy;

    modport master (
        output score, score_valid, DrawX, DrawY,
        input  rom_address, in_box, busy
    );

    modport slave (
        input  score, score_valid, DrawX, DrawY,
        output rom_address, in_box, busy
    );
endinterface

// File: rtl/score_digit_addr.sv
// Score digit address generator.
// Converts a binary score into four BCD digits using a serial double-dabble
// and, for every pixel, produces the numbers-ROM glyph address plus an in_box
// qualifier for the 32x16 score box. The displayed digits are committed only
// at frame start, so one frame never shows two different scores.
// Ports:
//   vga_clk : pixel clock
//   reset_n : asynchronous active-low reset
//   bus     : score_digit_addr_if slave modport (score request, pixel
//             coordinates, rom_address/in_box/busy outputs)
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | no conversion running; picks up a pending request
// CONV       | SCORE_W cycles of double-dabble shift/adjust
// WAIT_FRAME | BCD result ready, waiting for pixel (0,0) to commit it
module score_digit_addr #(
    parameter int ORIGIN_X = 16,
    parameter int ORIGIN_Y = 16,
    parameter int SCORE_W  = 14
) (
    input logic              vga_clk,
    input logic              reset_n,
    score_digit_addr_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONV       = 2'd1,
        WAIT_FRAME = 2'd2
    } state_t;

    localparam int CW = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam logic [CW-1:0]      CNT_LOAD  = CW'(SCORE_W - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(9999);

    state_t             state_q;
    logic [SCORE_W-1:0] req_score_q;
    logic               req_pend_q;
    logic [SCORE_W-1:0] shift_q;
    logic [SCORE_W-1:0] shift_d;
    logic [15:0]        bcd_q;
    logic [15:0]        bcd_d;
    logic [15:0]        bcd_adj;
    logic [CW-1:0]      cnt_q;
    logic [15:0]        disp_bcd_q;

    logic [10:0]        rom_address_q;
    logic               in_box_s1_q;
    logic               in_box_q;

    logic               frame_start;
    logic [SCORE_W-1:0] score_sat;

    assign frame_start = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);
    assign score_sat   = (32'(bus.score) > 32'd9999) ? SCORE_MAX : bus.score;

    // One double-dabble step: nibble correction first, then a joint shift of
    // the BCD accumulator and the binary shift register.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_score_q <= '0;
            req_pend_q  <= 1'b0;
            shift_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            disp_bcd_q  <= '0;
        end else begin
            // The request latch is independent of the state, so a new value
            // can land at any time; the newest one always wins.
            if (bus.score_valid) begin
                req_score_q <= score_sat;
                req_pend_q  <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (req_pend_q) begin
                        shift_q <= req_score_q;
                        bcd_q   <= '0;
                        cnt_q   <= CNT_LOAD;
                        // A request arriving on the transfer cycle must stay pending.
                        if (!bus.score_valid) begin
                            req_pend_q <= 1'b0;
                        end
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    shift_q <= shift_d;
                    bcd_q   <= bcd_d;
                    if (cnt_q == '0) begin
                        state_q <= WAIT_FRAME;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                WAIT_FRAME: begin
                    if (frame_start) begin
                        disp_bcd_q <= bcd_q;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pixel position relative to the box; negative offsets set bit 10, so a
    // single zero test on the upper bits covers both range limits.
    logic [10:0] rx;
    logic [10:0] ry;
    logic        in_range;
    logic [1:0]  dsel;
    logic [3:0]  digit;
    logic [3:0]  blank_vec;

    assign rx       = {1'b0, bus.DrawX} - 11'(ORIGIN_X);
    assign ry       = {1'b0, bus.DrawY} - 11'(ORIGIN_Y);
    assign in_range = (rx[10:5] == 6'd0) && (ry[10:4] == 7'd0);
    assign dsel     = ~rx[4:3];
    assign digit    = disp_bcd_q[{dsel, 2'b00} +: 4];

    assign blank_vec[3] = (disp_bcd_q[15:12] == 4'd0);
    assign blank_vec[2] = blank_vec[3] && (disp_bcd_q[11:8] == 4'd0);
    assign blank_vec[1] = blank_vec[2] && (disp_bcd_q[7:4] == 4'd0);
    assign blank_vec[0] = 1'b0;

    // in_box gets a second stage so it lines up with the ROM read data.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address_q <= '0;
            in_box_s1_q   <= 1'b0;
            in_box_q      <= 1'b0;
        end else begin
            rom_address_q <= in_range ? {digit, ry[3:0], rx[2:0]} : 11'd0;
            in_box_s1_q   <= in_range && !blank_vec[dsel];
            in_box_q      <= in_box_s1_q;
        end
    end

    assign bus.rom_address = rom_address_q;
    assign bus.in_box      = in_box_q;
    assign bus.busy        = (state_q != IDLE) || req_pend_q;

endmodule

// File: tb/tb_score_digit_addr.sv
// Directed testbench for score_digit_addr: reset values, digit conversion,
// saturation, back-to-back updates, frame-aligned commit, reset during
// conversion and box boundary pixels.
module tb_score_digit_addr;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    score_digit_addr_if #(.SCORE_W(14)) bus ();

    score_digit_addr #(
        .ORIGIN_X(16),
        .ORIGIN_Y(16),
        .SCORE_W (14)
    ) dut (
        .vga_clk(clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Park the pixel outside the box and away from (0,0).
    task automatic park();
        bus.DrawX = 10'd100;
        bus.DrawY = 10'd100;
    endtask

    task automatic pulse(input logic [13:0] val);
        @(negedge clk);
        bus.score       = val;
        bus.score_valid = 1'b1;
        @(negedge clk);
        bus.score_valid = 1'b0;
    endtask

    // Present one pixel; address is checked one cycle later, in_box two.
    task automatic pix(input string tag, input int x, input int y,
                       input int exp_addr, input logic exp_box);
        @(negedge clk);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        @(negedge clk);
        chk({tag, "_addr"}, 32'(bus.rom_address), 32'(exp_addr));
        @(negedge clk);
        chk({tag, "_inbox"}, 32'(bus.in_box), 32'(exp_box));
        park();
    endtask

    task automatic frame();
        @(negedge clk);
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
        @(negedge clk);
        park();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.score       = '0;
        bus.score_valid = 1'b0;
        bus.DrawX       = 10'd40;
        bus.DrawY       = 10'd20;

        // Reset: outputs held at zero even with an in-box pixel presented.
        step(3);
        chk("rst_addr", 32'(bus.rom_address), 32'd0);
        chk("rst_inbox", 32'(bus.in_box), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        park();
        rst_n = 1'b1;
        step(2);

        // Display "0": only the rightmost cell is visible.
        pix("z_d0", 40, 20, 32, 1'b1);
        pix("z_d3", 16, 16, 0, 1'b0);
        pix("z_d2", 30, 17, 14, 1'b0);

        // 1234 commits only at pixel (0,0).
        pulse(14'd1234);
        chk("s1234_busy", 32'(bus.busy), 32'd1);
        step(30);
        chk("s1234_busy_wait", 32'(bus.busy), 32'd1);
        pix("s1234_pre", 16, 16, 0, 1'b0);
        frame();
        chk("s1234_busy_done", 32'(bus.busy), 32'd0);
        pix("s1234_d3", 16, 16, 128, 1'b1);
        pix("s1234_d0_br", 47, 31, 639, 1'b1);
        pix("s1234_d2", 24, 16, 256, 1'b1);
        pix("s1234_d1", 32, 16, 384, 1'b1);

        // 70000 truncates to 4464; a frame start during CONV must not commit.
        pulse(14'(70000));
        step(4);
        frame();
        pix("s4464_early", 16, 16, 128, 1'b1);
        step(30);
        frame();
        pix("s4464_d3", 16, 16, 512, 1'b1);
        pix("s4464_d2", 24, 16, 512, 1'b1);
        pix("s4464_d1", 32, 16, 768, 1'b1);
        pix("s4464_d0", 40, 16, 512, 1'b1);

        // 12000 saturates to 9999.
        pulse(14'd12000);
        step(30);
        frame();
        pix("s9999_d3", 16, 16, 1152, 1'b1);
        pix("s9999_d0", 47, 31, 1152 + 127, 1'b1);

        // 5 then 8 three cycles apart: 8 is what remains displayed.
        pulse(14'd5);
        step(2);
        pulse(14'd8);
        step(30);
        frame();
        step(30);
        frame();
        chk("s8_busy", 32'(bus.busy), 32'd0);
        pix("s8_d0", 40, 16, 1024, 1'b1);
        pix("s8_d3", 16, 16, 0, 1'b0);
        pix("s8_d2", 24, 16, 0, 1'b0);
        pix("s8_d1", 32, 16, 0, 1'b0);

        // Mid-frame request: pixels keep using the old value until (0,0).
        pulse(14'd1234);
        step(30);
        pix("mid_d0_old", 40, 16, 1024, 1'b1);
        pix("mid_d3_old", 16, 16, 0, 1'b0);
        frame();
        pix("mid_d0_new", 40, 16, 512, 1'b1);

        // Reset during CONV: immediate zero outputs, display back to "0".
        bus.DrawX = 10'd40;
        bus.DrawY = 10'd16;
        pulse(14'd9876);
        step(3);
        chk("rstc_addr_pre", 32'(bus.rom_address), 32'd512);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstc_addr", 32'(bus.rom_address), 32'd0);
        chk("rstc_inbox", 32'(bus.in_box), 32'd0);
        chk("rstc_busy", 32'(bus.busy), 32'd0);
        step(2);
        rst_n = 1'b1;
        park();
        step(30);
        frame();
        chk("rstc_busy_after", 32'(bus.busy), 32'd0);
        pix("rstc_d0", 40, 16, 0, 1'b1);
        pix("rstc_d3", 16, 16, 0, 1'b0);

        // Box boundaries.
        pix("b_x15", 15, 20, 0, 1'b0);
        pix("b_y32", 20, 32, 0, 1'b0);
        pix("b_x48", 48, 20, 0, 1'b0);
        pix("b_y15", 16, 15, 0, 1'b0);
        pix("b_y31", 40, 31, 120, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_digit_addr.md
# score_digit_addr

Converts the binary game score into four decimal digits and, for each pixel of the visible frame, generates the 11-bit glyph address consumed by the 1-bit numbers ROM/palette draw stage, plus an aligned `in_box` qualifier for the score box. It sits directly upstream of the numbers draw stage. It is driven by the VGA controller's DrawX/DrawY and by the game logic's score update pulse. Digit updates are committed only at frame start, so a score never tears mid-frame.

## Interface
- `ORIGIN_X`, 16: left pixel column of the score box.
- `ORIGIN_Y`, 16: top pixel row of the score box.
- `SCORE_W`, 14: width of the binary score input.
- Fixed geometry:
  - 4 digits, each glyph 8 wide × 16 tall, box 32×16.
  - ROM address = digit×128 + row×8 + col, for digit 0–9.

- `vga_clk` in 1: pixel clock, the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `score` in SCORE_W: binary score, sampled on `score_valid`.
- `score_valid` in 1: one-cycle update request.
- `DrawX` in 10: current pixel column, 0–799.
- `DrawY` in 10: current pixel row, 0–524.
- `rom_address` out 11: glyph bit address to the numbers ROM.
- `in_box` out 1: pixel is inside a non-blanked digit cell. Aligned with the ROM's `q` output.
- `busy` out 1: conversion or commit pending.

## Operation
- **Request latch**
  - `score_valid` loads `req_score` and sets `req_pend`, in any state.
  - Last write wins. Scores above 9999 saturate to 9999 at load.
- **FSM states:** IDLE, CONV, WAIT_FRAME.
  - IDLE:
    - If `req_pend`, copy `req_score` into the shift register.
    - Clear the BCD accumulator and `req_pend`, then go to CONV.
    - `score_valid` in the same cycle as this transfer wins: `req_pend` stays set.
  - CONV: runs exactly SCORE_W cycles of double-dabble (add 3 to each nibble ≥5, then shift left 1). Then go to WAIT_FRAME.
  - WAIT_FRAME:
    - `frame_start` is defined as DrawX==0 && DrawY==0.
    - On `frame_start`, copy the BCD result into the 16-bit `disp_bcd` register and go to IDLE.
    - If `frame_start` coincides with the last CONV cycle, the commit waits for the next frame.
- `busy` = state≠IDLE || `req_pend`.
- **Leading-zero blanking**
  - Digits 3..1 are blank while every higher digit, and the digit itself, is zero.
  - Digit 0 is never blank, so a score of 0 shows "0".
- **Address generation**
  - `rx` = DrawX−ORIGIN_X and `ry` = DrawY−ORIGIN_Y, computed as 11-bit signed values.
  - The pixel is in range when 0≤`rx`<32 and 0≤`ry`<16.
  - `dsel` = 3−`rx`[4:3], so the leftmost cell is the most significant digit.
  - `rom_address` = {`disp_bcd`[dsel], `ry`[3:0], `rx`[2:0]}, i.e. digit×128 + row×8 + col.
  - When out of range, `rom_address` = 0.
  - `in_box` = in-range && !blank(dsel).
- **Reset**
  - Outputs: `rom_address`=0, `in_box`=0, `busy`=0.
  - Internal: state IDLE, `disp_bcd`=0 (display shows "0"), `req_pend`=0.
  - Reset mid-CONV discards the conversion. No partial commit.

## Timing
- `rom_address` is registered: valid 1 cycle after the DrawX/DrawY it corresponds to.
- The ROM adds 1 cycle, so `in_box` is delayed 2 cycles from DrawX/DrawY and aligns with `q`.
- **Conversion latency**
  - `score_valid` → `req_pend` at edge +1.
  - Leaves IDLE at +2.
  - Result ready after SCORE_W CONV cycles, then waits up to one frame (420 000 cycles) for `frame_start`.
- `disp_bcd` changes only on the cycle after `frame_start` has been sampled. All pixels of one frame therefore use one value.
- Back-to-back `score_valid` pulses are never lost in value: the final value is always displayed, possibly one frame later.

## Test plan
- Reset released with no update → scan of the box: only digit 0 cell has `in_box`=1. At DrawX=40, DrawY=20, `rom_address`=0×128+4×8+0=32, and `in_box`=1 two cycles later.
- `score`=1234 pulse → `busy` rises, the commit occurs at the next (0,0). At DrawX=16, DrawY=16, `rom_address`=128; at DrawX=47, DrawY=31, `rom_address`=4×128+15×8+7=639.
- `score`=70000 (wraps to 4464 at 14 bits), then `score`=12000 → saturates, the display reads 9999 and digit 3 address base is 1152.
- `score`=5 and `score`=8 pulsed 3 cycles apart → only "8" is displayed after the frame commit, with digits 3..1 `in_box`=0.
- `score_valid` asserted mid-frame → `disp_bcd` is unchanged until DrawX=0, DrawY=0 and no pixel row shows mixed digits. `reset_n` low during CONV → outputs return to 0 immediately and the display reverts to "0".
- Pixel at DrawX=15 or DrawY=32 → `rom_address`=0 and `in_box`=0.
